// File: rtl/alu_pkg.sv
// Shared ALU constants and the immediate-extension classifier.
// Used by alu_operand_stage and register_file.
package alu_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned CTRL_W   = 4;
    localparam int unsigned IMM_W    = 16;

    localparam logic [CTRL_W-1:0] AluAnd = 4'b0000;
    localparam logic [CTRL_W-1:0] AluOr  = 4'b0001;
    localparam logic [CTRL_W-1:0] AluAdd = 4'b0010;
    localparam logic [CTRL_W-1:0] AluSub = 4'b0110;
    localparam logic [CTRL_W-1:0] AluSlt = 4'b0111;
    localparam logic [CTRL_W-1:0] AluXor = 4'b1010;
    localparam logic [CTRL_W-1:0] AluNor = 4'b1100;
    localparam logic [CTRL_W-1:0] AluLui = 4'b1110;

    // Logical ops take a zero-extended immediate; everything else sign-extends.
    function automatic logic is_logical(input logic [CTRL_W-1:0] code);
        return (code == AluAnd) || (code == AluOr) || (code == AluXor) ||
               (code == AluNor) || (code == AluLui);
    endfunction

endpackage

// File: rtl/register_file.sv
// Register file with two combinational read ports and one write port.
// Entry 0 reads as zero and is never written; asynchronous active-low clear.
module register_file
    import alu_pkg::*;
#(
    parameter int unsigned Width = DATA_W,
    parameter int unsigned Depth = NUM_REGS
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_AW-1:0] i_raddr_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [Width-1:0]  o_rdata_a,
    output logic [Width-1:0]  o_rdata_b,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [Width-1:0]  i_wdata
);

    logic [Width-1:0] r_mem [Depth];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch/issue stage: register file, operand forwarding and the ID/EX register.
// OPSTAGE_FWD_EN enables EX forward, WB bypass and stall refresh of held operands.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned n    = DATA_W,
    parameter int unsigned REGS = NUM_REGS
) (
    input  logic              Clk,
    input  logic              Reset_L,
    input  logic              InValid,
    output logic              InReady,
    input  logic [REG_AW-1:0] RA,
    input  logic [REG_AW-1:0] RB,
    input  logic [IMM_W-1:0]  Imm,
    input  logic              ALUSrc,
    input  logic [CTRL_W-1:0] ALUCtrlIn,
    input  logic [REG_AW-1:0] RdIn,
    input  logic              RegWrIn,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [n-1:0]      ExResult,
    input  logic [REG_AW-1:0] RW,
    input  logic [n-1:0]      WbData,
    input  logic              RegWr,
    output logic [n-1:0]      BusA,
    output logic [n-1:0]      BusB,
    output logic [CTRL_W-1:0] ALUCtrl,
    output logic [REG_AW-1:0] RdOut,
    output logic              RegWrOut,
    output logic              OutValid
);

    logic [n-1:0]      w_rf_a;
    logic [n-1:0]      w_rf_b;
    logic [n-1:0]      w_op_a;
    logic [n-1:0]      w_op_b;
    logic [n-1:0]      w_imm_ext;
    logic [n-1:0]      w_bus_b_in;

    logic [n-1:0]      r_bus_a;
    logic [n-1:0]      r_bus_b;
    logic [CTRL_W-1:0] r_alu_ctrl;
    logic [REG_AW-1:0] r_rd;
    logic              r_reg_wr;
    logic              r_valid;
    logic [REG_AW-1:0] r_ra;
    logic [REG_AW-1:0] r_rb;
    logic              r_alusrc;

    register_file #(
        .Width (n),
        .Depth (REGS)
    ) u_register_file (
        .i_clk     (Clk),
        .i_rst_n   (Reset_L),
        .i_raddr_a (RA),
        .i_raddr_b (RB),
        .o_rdata_a (w_rf_a),
        .o_rdata_b (w_rf_b),
        .i_we      (RegWr),
        .i_waddr   (RW),
        .i_wdata   (WbData)
    );

`ifdef OPSTAGE_FWD_EN
    // EX forward beats WB bypass; the in-stage result is the younger value.
    always_comb begin
        w_op_a = w_rf_a;
        if (RA == '0) begin
            w_op_a = '0;
        end else if (r_valid && r_reg_wr && (r_rd == RA)) begin
            w_op_a = ExResult;
        end else if (RegWr && (RW == RA)) begin
            w_op_a = WbData;
        end
    end

    always_comb begin
        w_op_b = w_rf_b;
        if (RB == '0) begin
            w_op_b = '0;
        end else if (r_valid && r_reg_wr && (r_rd == RB)) begin
            w_op_b = ExResult;
        end else if (RegWr && (RW == RB)) begin
            w_op_b = WbData;
        end
    end
`else
    logic w_unused_fwd;

    assign w_op_a       = w_rf_a;
    assign w_op_b       = w_rf_b;
    assign w_unused_fwd = ^{ExResult, r_ra, r_rb, r_alusrc};
`endif

    assign w_imm_ext  = is_logical(ALUCtrlIn) ? {{(n-IMM_W){1'b0}}, Imm}
                                              : {{(n-IMM_W){Imm[IMM_W-1]}}, Imm};
    assign w_bus_b_in = ALUSrc ? w_imm_ext : w_op_b;

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            r_bus_a    <= '0;
            r_bus_b    <= '0;
            r_alu_ctrl <= AluAnd;
            r_rd       <= '0;
            r_reg_wr   <= 1'b0;
            r_valid    <= 1'b0;
            r_ra       <= '0;
            r_rb       <= '0;
            r_alusrc   <= 1'b0;
        end else if (Flush) begin
            r_valid  <= 1'b0;
            r_reg_wr <= 1'b0;
        end else if (Stall) begin
`ifdef OPSTAGE_FWD_EN
            // Keep held operands coherent with write-backs that land during the stall.
            if (r_valid && RegWr && (RW != '0)) begin
                if (RW == r_ra) begin
                    r_bus_a <= WbData;
                end
                if (!r_alusrc && (RW == r_rb)) begin
                    r_bus_b <= WbData;
                end
            end
`endif
        end else begin
            r_bus_a    <= w_op_a;
            r_bus_b    <= w_bus_b_in;
            r_alu_ctrl <= ALUCtrlIn;
            r_rd       <= RdIn;
            r_reg_wr   <= RegWrIn & InValid;
            r_valid    <= InValid;
            r_ra       <= RA;
            r_rb       <= RB;
            r_alusrc   <= ALUSrc;
        end
    end

    assign InReady  = !Stall;
    assign BusA     = r_bus_a;
    assign BusB     = r_bus_b;
    assign ALUCtrl  = r_alu_ctrl;
    assign RdOut    = r_rd;
    assign RegWrOut = r_reg_wr;
    assign OutValid = r_valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized bench for alu_operand_stage against a behavioural pipeline model.
// Honours OPSTAGE_FWD_EN the same way the design does.
module tb_alu_operand_stage;

    logic        Clk = 1'b0;
    logic        Reset_L;
    logic        InValid, InReady;
    logic [4:0]  RA, RB, RdIn, RW, RdOut;
    logic [15:0] Imm;
    logic        ALUSrc, RegWrIn, Stall, Flush, RegWr, RegWrOut, OutValid;
    logic [3:0]  ALUCtrlIn, ALUCtrl;
    logic [31:0] ExResult, WbData, BusA, BusB;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference state: architectural registers and the one-deep stage contents.
    logic [31:0] m_reg [32];
    logic [31:0] m_busa, m_busb;
    logic [3:0]  m_ctrl;
    logic [4:0]  m_rd, m_ra, m_rb;
    logic        m_rw, m_v, m_src;

    always #5 Clk = ~Clk;

    alu_operand_stage dut (
        .Clk       (Clk),
        .Reset_L   (Reset_L),
        .InValid   (InValid),
        .InReady   (InReady),
        .RA        (RA),
        .RB        (RB),
        .Imm       (Imm),
        .ALUSrc    (ALUSrc),
        .ALUCtrlIn (ALUCtrlIn),
        .RdIn      (RdIn),
        .RegWrIn   (RegWrIn),
        .Stall     (Stall),
        .Flush     (Flush),
        .ExResult  (ExResult),
        .RW        (RW),
        .WbData    (WbData),
        .RegWr     (RegWr),
        .BusA      (BusA),
        .BusB      (BusB),
        .ALUCtrl   (ALUCtrl),
        .RdOut     (RdOut),
        .RegWrOut  (RegWrOut),
        .OutValid  (OutValid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_operand(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef OPSTAGE_FWD_EN
        if (m_v && m_rw && (m_rd == a)) return ExResult;
        if (RegWr && (RW == a)) return WbData;
`endif
        return m_reg[a];
    endfunction

    function automatic logic [31:0] m_imm(input logic [3:0] code, input logic [15:0] imm);
        if (code inside {4'h0, 4'h1, 4'hA, 4'hC, 4'hE}) return {16'h0000, imm};
        return {{16{imm[15]}}, imm};
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_busa = 0; m_busb = 0; m_ctrl = 0; m_rd = 0; m_ra = 0; m_rb = 0;
        m_rw = 0; m_v = 0; m_src = 0;
    endtask

    task automatic idle();
        InValid = 0; RA = 0; RB = 0; Imm = 0; ALUSrc = 0; ALUCtrlIn = 4'h2;
        RdIn = 0; RegWrIn = 0; Stall = 0; Flush = 0; ExResult = 0;
        RW = 0; WbData = 0; RegWr = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".busa"}, BusA, m_busa);
        check_eq({tag, ".busb"}, BusB, m_busb);
        check_eq({tag, ".ctrl"}, {28'd0, ALUCtrl}, {28'd0, m_ctrl});
        check_eq({tag, ".rd"}, {27'd0, RdOut}, {27'd0, m_rd});
        check_eq({tag, ".rw"}, {31'd0, RegWrOut}, {31'd0, m_rw});
        check_eq({tag, ".v"}, {31'd0, OutValid}, {31'd0, m_v});
    endtask

    // Inputs are already driven; predict, clock once, update model, compare.
    task automatic step(input string tag);
        logic [31:0] na, nb;
        #1;
        check_eq({tag, ".ready"}, {31'd0, InReady}, {31'd0, !Stall});
        na = m_operand(RA);
        nb = ALUSrc ? m_imm(ALUCtrlIn, Imm) : m_operand(RB);
        @(posedge Clk);
        if (Flush) begin
            m_v = 0; m_rw = 0;
        end else if (Stall) begin
`ifdef OPSTAGE_FWD_EN
            if (m_v && RegWr && RW != 0) begin
                if (RW == m_ra) m_busa = WbData;
                if (!m_src && RW == m_rb) m_busb = WbData;
            end
`endif
        end else begin
            m_busa = na; m_busb = nb; m_ctrl = ALUCtrlIn; m_rd = RdIn;
            m_rw = RegWrIn & InValid; m_v = InValid;
            m_ra = RA; m_rb = RB; m_src = ALUSrc;
        end
        if (RegWr && RW != 0) m_reg[RW] = WbData;
        #1;
        check_outputs(tag);
    endtask

    task automatic async_reset();
        #2 Reset_L = 0;
        #1;
        m_clear();
        check_outputs("reset");
        #1 Reset_L = 1;
    endtask

    logic [31:0] old4;

    initial begin
        idle();
        Reset_L = 0;
        m_clear();
        #12;
        check_outputs("por");
        Reset_L = 1;
        @(negedge Clk);

        // Write then read.
        idle(); RegWr = 1; RW = 3; WbData = 32'h12345678; step("wb3");
        idle(); InValid = 1; RA = 3; step("rd3");
        check_eq("wr_rd", BusA, 32'h12345678);

        // EX forward vs. old register value.
        idle(); RegWr = 1; RW = 4; WbData = 32'h44444444; step("wb4");
        old4 = 32'h44444444;
        idle(); InValid = 1; RegWrIn = 1; RdIn = 4; step("iss4");
        idle(); InValid = 1; RA = 4; ExResult = 32'hAAAA0000; step("fwd4");
`ifdef OPSTAGE_FWD_EN
        check_eq("ex_fwd", BusA, 32'hAAAA0000);
`else
        check_eq("ex_fwd", BusA, old4);
`endif

        // Immediate extension and r0.
        idle(); InValid = 1; ALUSrc = 1; Imm = 16'h8001; ALUCtrlIn = 4'h2; step("imm_add");
        check_eq("imm_sext", BusB, 32'hFFFF8001);
        idle(); InValid = 1; ALUSrc = 1; Imm = 16'h8001; ALUCtrlIn = 4'h1; step("imm_or");
        check_eq("imm_zext", BusB, 32'h00008001);
        idle(); InValid = 1; RA = 0; RegWr = 1; RW = 0; WbData = 32'hDEADBEEF; step("r0");
        check_eq("r0_zero", BusA, 32'd0);

        // Stall refresh of held RB.
        idle(); InValid = 1; RB = 7; ALUCtrlIn = 4'h6; step("iss7");
        idle(); Stall = 1; RegWr = 1; RW = 7; WbData = 32'h55; step("stall7");
`ifdef OPSTAGE_FWD_EN
        check_eq("stall_refresh", BusB, 32'h55);
`else
        check_eq("stall_refresh", BusB, 32'd0);
`endif
        check_eq("stall_ctrl", {28'd0, ALUCtrl}, 32'h6);

        // Flush together with stall.
        idle(); InValid = 1; RegWrIn = 1; RdIn = 9; step("iss9");
        idle(); Stall = 1; Flush = 1; step("flush");
        check_eq("flush_v", {31'd0, OutValid}, 32'd0);
        check_eq("flush_rw", {31'd0, RegWrOut}, 32'd0);
        check_eq("stall_ready", {31'd0, InReady}, 32'd0);

        // Mid-stream reset, then r5 must read back as zero.
        idle(); RegWr = 1; RW = 5; WbData = 32'hCAFEF00D; InValid = 1; step("wb5");
        async_reset();
        idle(); InValid = 1; RA = 5; step("rd5");
        check_eq("r5_after_reset", BusA, 32'd0);

        // Random traffic on a narrow register window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            InValid   = 1'($urandom_range(0, 3) != 0);
            RA        = 5'($urandom_range(0, 7));
            RB        = 5'($urandom_range(0, 7));
            RdIn      = 5'($urandom_range(0, 7));
            RW        = 5'($urandom_range(0, 7));
            Imm       = 16'($urandom);
            ALUSrc    = 1'($urandom_range(0, 2) == 0);
            ALUCtrlIn = 4'($urandom);
            RegWrIn   = 1'($urandom);
            RegWr     = 1'($urandom);
            Stall     = 1'($urandom_range(0, 3) == 0);
            Flush     = 1'($urandom_range(0, 9) == 0);
            ExResult  = $urandom;
            WbData    = $urandom;
            step("rand");
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch/issue stage directly upstream of the ALU. It holds the 32×32 register file and the ID/EX pipeline register. It forwards results from the ALU output and the write-back port, and drives the ALU's `BusA`, `BusB` and `ALUCtrl` inputs from registered state. The stage accepts one decoded instruction per cycle, with stall and flush control from the hazard unit.

## Interface
- `n`, 32, datapath width
- `REGS`, 32, register count (addresses are 5 bits)
- `Clk`  in  1  rising-edge clock
- `Reset_L`  in  1  asynchronous, active-low reset
- `InValid`  in  1  decoded instruction present
- `InReady`  out  1  stage can accept; equals `!Stall`
- `RA`, `RB`  in  5  source register addresses
- `Imm`  in  16  immediate field
- `ALUSrc`  in  1  1: `BusB` takes the extended `Imm`
- `ALUCtrlIn`  in  4  ALU operation code
- `RdIn`  in  5  destination register
- `RegWrIn`  in  1  instruction writes `RdIn`
- `Stall`  in  1  hold stage contents
- `Flush`  in  1  kill stage contents
- `ExResult`  in  n  ALU result of the instruction currently in this stage
- `RW`  in  5  write-back address
- `WbData`  in  n  write-back data
- `RegWr`  in  1  write-back enable
- `BusA`, `BusB`  out  n  registered ALU operands
- `ALUCtrl`  out  4  registered ALU operation
- `RdOut`  out  5  registered destination
- `RegWrOut`  out  1  registered write enable, qualified by valid
- `OutValid`  out  1  stage holds a live instruction

## Operation
- **Register file write**
  - On a `Clk` rising edge, if `RegWr` is high and `RW` != 0, `reg[RW] <= WbData`.
  - The write happens independent of `Stall` and `Flush`.
  - `reg[0]` always reads 0 and is never written.
- **Operand select, per source `RA` (same rules for `RB`)**
  - If `RA` == 0, the operand is 0.
  - Else if `OutValid`, `RegWrOut` and `RdOut` == `RA`, the operand is `ExResult` (EX forward).
  - Else if `RegWr` and `RW` == `RA`, the operand is `WbData` (WB bypass).
  - Otherwise the operand is `reg[RA]`.
- **B operand with `ALUSrc` = 1**
  - `BusB` gets `Imm`, zero-extended when `ALUCtrlIn` is AND (0000), OR (0001), XOR (1010), NOR (1100) or LUI (1110).
  - For every other code, `Imm` is sign-extended.
- **Pipeline register priority on each edge**
  - `Flush`: `OutValid <= 0` and `RegWrOut <= 0`; the other fields hold.
  - Else `Stall`: all fields hold, except for the stall refresh below.
  - Else capture: `BusA`, `BusB`, `ALUCtrl <= ALUCtrlIn`, `RdOut <= RdIn`, `RegWrOut <= RegWrIn & InValid`, `OutValid <= InValid`. The stage also keeps internal copies of `RA`, `RB` and `ALUSrc`.
- **Stall refresh**
  - While stalled with `OutValid` = 1, a write-back (`RegWr`, `RW` != 0) whose `RW` matches the held `RA` updates `BusA` to `WbData`.
  - A match on the held `RB` updates `BusB` the same way, but only if the held `ALUSrc` is 0.
- **Simultaneous events**
  - `Flush` together with `Stall`: flush wins.
  - Write-back to the register being read: the new value is used.
  - EX-forward and WB-bypass both match: EX wins.
- **Reset**
  - `Reset_L` low asynchronously clears all registers, `BusA`, `BusB`, `RdOut`, `RegWrOut` and `OutValid` to 0, and sets `ALUCtrl` to 0000.
  - This applies mid-operation as well; any in-flight instruction is dropped.

## Timing
- Latency is one cycle: an instruction accepted at edge k appears on the outputs after edge k.
- Register file reads and operand select are combinational in the same cycle as `InValid`.
- `ExResult` must settle before the next edge, inside the ALU's combinational delay budget.
- `InReady` is combinational from `Stall`.
- Throughput is one instruction per cycle when not stalled.

## Configuration
- `OPSTAGE_FWD_EN` defined:
  - EX forward, WB bypass and stall refresh are all present as described above.
- `OPSTAGE_FWD_EN` undefined:
  - Operands come from `reg[]` only, as values before the write on the same edge.
  - Held operands are never refreshed.
  - `ExResult` is ignored and the hazard unit must insert bubbles.
  - The port list is unchanged.

## Structure
- Shared package `alu_pkg`:
  - ALU control code constants (AND 0000 … LUI 1110).
  - Width constants for data, register address and control.
  - A helper that classifies a code as logical (zero-extend) or arithmetic (sign-extend).
- Sub-module `register_file`:
  - Two combinational read ports and one write port, register 0 hardwired to zero, asynchronous clear.
  - Forwarding mux and pipeline register stay in `alu_operand_stage`.

## Test plan
- **Reset value:** `Reset_L` = 0 mid-stream -> all outputs 0 immediately; `reg[5]` reads 0 afterwards.
- **Write then read:** WB `RW`=3, `WbData`=0x12345678, then issue `RA`=3 -> `BusA`=0x12345678.
- **EX forward:** in-stage instruction has `RdOut`=4, `RegWrOut`=1, `ExResult`=0xAAAA0000; issue `RA`=4 -> `BusA`=0xAAAA0000. Without `OPSTAGE_FWD_EN` -> old `reg[4]`.
- **Immediate extension:**
  - `Imm`=0x8001 with ADD -> `BusB`=0xFFFF8001.
  - `Imm`=0x8001 with OR -> `BusB`=0x00008001.
  - `RA`=0, any prior writes -> `BusA`=0.
- **Stall refresh:** stall with held `RB`=7, `ALUSrc`=0; WB writes `reg[7]`=0x55 -> `BusB`=0x55 while held; `ALUCtrl` unchanged.
- **Flush with stall:** `Flush`=1 and `Stall`=1 together -> `OutValid`=0, `RegWrOut`=0 next cycle; `InReady`=0 during the stall.
